// File: rtl/spawner_pkg.sv
// Shared types and helpers for the object spawner.
package spawner_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StGap,
        StLaunch,
        StFlight,
        StOver
    } state_t;

    // The dropper reports a bottom-row match one row past the last row.
    localparam logic [2:0] BOTTOM_CHECK = 3'd0;
    localparam int unsigned NUM_COLS = 8;

    function automatic logic [2:0] level_of(input logic [7:0] score);
        return (score >= 8'd56) ? 3'd7 : score[5:3];
    endfunction

    function automatic logic [7:0] gap_for(input logic [7:0] base, input logic [7:0] min_gap,
                                           input logic [2:0] level);
        logic [7:0] g;
        g = base >> level;
        return (g < min_gap) ? min_gap : g;
    endfunction

    // Never repeat the previous column; wraps modulo the 8 columns.
    function automatic logic [2:0] pick_col(input logic [7:0] rnd, input logic [2:0] prev);
        logic [2:0] col;
        col = rnd[2:0];
        if (col == prev) begin
            col = col + 3'd1;
        end
        return col;
    endfunction

    function automatic logic is_catch(input logic [5:0] addr);
        return addr[2:0] == BOTTOM_CHECK;
    endfunction

endpackage

// File: rtl/object_spawner_if.sv
// Launch/outcome handshake between the spawner and the dropping-object engine.
interface object_spawner_if;
    logic       go;
    logic [5:0] spawn_addr;
    logic [7:0] spawn_data;
    logic [5:0] speed;
    logic [5:0] obj_addr;
    logic       obj_done;
    logic       obj_lose;

    modport master (
        output go, spawn_addr, spawn_data, speed,
        input  obj_addr, obj_done, obj_lose
    );

    modport slave (
        input  go, spawn_addr, spawn_data, speed,
        output obj_addr, obj_done, obj_lose
    );
endinterface

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, free running.
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    output logic [7:0] state
);
    logic [7:0] state_q;
    logic       feedback;

    assign feedback = state_q[7] ^ state_q[5] ^ state_q[4] ^ state_q[3];
    assign state    = state_q;

    // Advance every cycle; reload the seed on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= SEED;
        end else begin
            state_q <= {state_q[6:0], feedback};
        end
    end
endmodule

// File: rtl/object_spawner.sv
// Game-side initiator: launches one falling object per round and scores outcomes.
module object_spawner
    import spawner_pkg::*;
#(
    parameter int unsigned BASE_GAP       = 64,
    parameter int unsigned MIN_GAP        = 4,
    parameter int unsigned FLIGHT_TIMEOUT = 32,
    parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    object_spawner_if.master  drop,
    output logic [7:0]        score,
    output logic [2:0]        level,
    output logic              game_over,
    output logic              fault,
    output logic              busy
);
    localparam logic [7:0] BaseGap    = 8'(BASE_GAP);
    localparam logic [7:0] MinGap     = 8'(MIN_GAP);
    localparam logic [7:0] FlightLast = 8'(FLIGHT_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] gap_q, gap_d;
    logic [7:0] flight_q, flight_d;
    logic [7:0] score_q, score_d;
    logic       fault_q, fault_d;
    logic [2:0] col_q, col_d;
    logic [5:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic [7:0] lfsr;
    logic [2:0] new_col;

    lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clock (clock),
        .reset (reset),
        .state (lfsr)
    );

    assign new_col = pick_col(lfsr, col_q);

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            gap_q    <= 8'd0;
            flight_q <= 8'd0;
            score_q  <= 8'd0;
            fault_q  <= 1'b0;
            col_q    <= 3'd0;
            addr_q   <= 6'd0;
            data_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            flight_q <= flight_d;
            score_q  <= score_d;
            fault_q  <= fault_d;
            col_q    <= col_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        flight_d = flight_q;
        score_d  = score_q;
        fault_d  = fault_q;
        col_d    = col_q;
        addr_d   = addr_q;
        data_d   = data_q;
        unique case (state_q)
            StIdle, StOver: begin
                if (start) begin
                    state_d = StGap;
                    score_d = 8'd0;
                    fault_d = 1'b0;
                    // Counter holds gap-1 so LAUNCH begins exactly gap edges later.
                    gap_d   = gap_for(BaseGap, MinGap, 3'd0) - 8'd1;
                end
            end
            StGap: begin
                if (gap_q == 8'd0) begin
                    state_d = StLaunch;
                    col_d   = new_col;
                    addr_d  = {new_col, 3'b000};
                    data_d  = 8'b1 << new_col;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            StLaunch: begin
                state_d  = StFlight;
                flight_d = 8'd0;
            end
            StFlight: begin
                // Priority: miss, catch, step, timeout.
                if (drop.obj_lose) begin
                    state_d = StOver;
                end else if (drop.obj_done && is_catch(drop.obj_addr)) begin
                    score_d = (score_q == 8'hFF) ? 8'hFF : score_q + 8'd1;
                    state_d = StGap;
                    gap_d   = gap_for(BaseGap, MinGap, level_of(score_d)) - 8'd1;
                end else if (drop.obj_done) begin
                    flight_d = 8'd0;
                end else if (flight_q == FlightLast) begin
                    fault_d = 1'b1;
                    state_d = StOver;
                end else begin
                    flight_d = flight_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from registered state.
    always_comb begin
        drop.go         = (state_q == StLaunch);
        drop.spawn_addr = addr_q;
        drop.spawn_data = data_q;
        drop.speed      = 6'd1;
        score           = score_q;
        level           = level_of(score_q);
        game_over       = (state_q == StOver);
        fault           = fault_q;
        busy            = (state_q == StLaunch) || (state_q == StFlight);
    end
endmodule

// File: tb/tb_object_spawner.sv
// Directed bench for object_spawner with a reference LFSR/column model.
module tb_object_spawner;
    localparam logic [7:0] SEED = 8'hA5;

    logic       clock;
    logic       reset;
    logic       start;
    logic [7:0] score;
    logic [2:0] level;
    logic       game_over;
    logic       fault;
    logic       busy;

    object_spawner_if drop_if ();

    object_spawner #(
        .BASE_GAP       (64),
        .MIN_GAP        (4),
        .FLIGHT_TIMEOUT (32),
        .LFSR_SEED      (SEED)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .drop      (drop_if.master),
        .score     (score),
        .level     (level),
        .game_over (game_over),
        .fault     (fault),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;

    // Reference LFSR; lfsr_hist is the value present just before the latest edge.
    logic [7:0] m_lfsr, lfsr_hist;
    logic [2:0] m_prev;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    always @(posedge clock) begin
        lfsr_hist <= m_lfsr;
        m_lfsr    <= reset ? SEED : lfsr_step(m_lfsr);
    end

    function automatic int exp_gap(input int sc);
        int lvl;
        int g;
        lvl = (sc >= 56) ? 7 : sc / 8;
        g = 64 >> lvl;
        return (g < 4) ? 4 : g;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        m_prev = 3'd0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_go(input int bound, output int n);
        bit found;
        found = 1'b0;
        n = -1;
        for (int i = 1; i <= bound && !found; i++) begin
            tick();
            if (drop_if.go) begin
                n = i;
                found = 1'b1;
            end
        end
    endtask

    task automatic check_launch();
        logic [2:0] c;
        c = lfsr_hist[2:0];
        if (c == m_prev) c = c + 3'd1;
        check("launch_addr", int'(drop_if.spawn_addr), int'({c, 3'b000}));
        check("launch_data", int'(drop_if.spawn_data), int'(8'b1 << c));
        check("launch_busy", int'(busy), 1);
        check("speed", int'(drop_if.speed), 1);
        m_prev = c;
    endtask

    // From the LAUNCH cycle: catch on the first FLIGHT cycle, return gap to next go.
    task automatic catch_one(output int gap_seen);
        tick();
        drop_if.obj_done = 1'b1;
        drop_if.obj_addr = 6'd8;
        tick();
        drop_if.obj_done = 1'b0;
        drop_if.obj_addr = 6'd0;
        wait_go(200, gap_seen);
    endtask

    typedef struct {
        logic       done;
        logic       lose;
        logic [5:0] addr;
        logic       exp_over;
        logic       exp_busy;
        logic [7:0] exp_score;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int n;
        int gocnt;
        int sc;
        bit found;
        logic [7:0] p;

        vecs[0] = '{1'b1, 1'b0, 6'd3,    1'b0, 1'b1, 8'd0};
        vecs[1] = '{1'b1, 1'b0, 6'd8,    1'b0, 1'b0, 8'd1};
        vecs[2] = '{1'b1, 1'b0, 6'd0,    1'b0, 1'b0, 8'd1};
        vecs[3] = '{1'b1, 1'b1, 6'd8,    1'b1, 1'b0, 8'd0};
        vecs[4] = '{1'b0, 1'b1, 6'd5,    1'b1, 1'b0, 8'd0};
        vecs[5] = '{1'b0, 1'b0, 6'd0,    1'b0, 1'b1, 8'd0};
        vecs[6] = '{1'b1, 1'b0, 6'h3F,   1'b0, 1'b1, 8'd0};
        vecs[7] = '{1'b1, 1'b0, 6'h38,   1'b0, 1'b0, 8'd1};

        reset = 1'b1;
        start = 1'b0;
        drop_if.obj_done = 1'b0;
        drop_if.obj_lose = 1'b0;
        drop_if.obj_addr = 6'd0;
        m_prev = 3'd0;

        // Reset, then idle 200 cycles with no start.
        tick();
        do_reset();
        gocnt = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (drop_if.go || busy) gocnt++;
        end
        check("idle_go_or_busy", gocnt, 0);
        check("idle_score", int'(score), 0);
        check("idle_level", int'(level), 0);
        check("idle_over", int'(game_over), 0);
        check("idle_fault", int'(fault), 0);
        check("idle_addr", int'(drop_if.spawn_addr), 0);
        check("idle_data", int'(drop_if.spawn_data), 0);
        check("idle_speed", int'(drop_if.speed), 1);

        // Start latency; start held through the gap must not restart it.
        start = 1'b1;
        tick();
        n = -1;
        found = 1'b0;
        for (int i = 1; i <= 200 && !found; i++) begin
            if (i == 20) start = 1'b0;
            tick();
            if (drop_if.go) begin
                n = i;
                found = 1'b1;
            end
        end
        start = 1'b0;
        check("start_latency", n, 64);
        check_launch();
        tick();
        check("go_one_cycle", int'(drop_if.go), 0);
        check("flight_busy", int'(busy), 1);

        // Step then catch.
        drop_if.obj_done = 1'b1;
        drop_if.obj_addr = 6'd3;
        tick();
        drop_if.obj_done = 1'b0;
        check("step_score", int'(score), 0);
        check("step_busy", int'(busy), 1);
        drop_if.obj_done = 1'b1;
        drop_if.obj_addr = 6'd8;
        tick();
        drop_if.obj_done = 1'b0;
        drop_if.obj_addr = 6'd0;
        check("catch_score", int'(score), 1);
        check("catch_busy", int'(busy), 0);
        wait_go(200, n);
        check("gap_after_1", n, 64);
        check_launch();

        // Catches up to and past saturation.
        for (int k = 2; k <= 256; k++) begin
            sc = (k > 255) ? 255 : k;
            catch_one(n);
            check($sformatf("score_%0d", k), int'(score), sc);
            check($sformatf("gap_%0d", k), n, exp_gap(sc));
            if (k == 8) check("level_8", int'(level), 1);
            if (k == 56) check("level_56", int'(level), 7);
            if (k == 256) check("level_sat", int'(level), 7);
            check_launch();
        end

        // Miss and done together: miss wins.
        tick();
        drop_if.obj_done = 1'b1;
        drop_if.obj_lose = 1'b1;
        drop_if.obj_addr = 6'd8;
        tick();
        drop_if.obj_done = 1'b0;
        drop_if.obj_lose = 1'b0;
        drop_if.obj_addr = 6'd0;
        check("miss_over", int'(game_over), 1);
        check("miss_score", int'(score), 255);
        gocnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (drop_if.go) gocnt++;
        end
        check("over_no_go", gocnt, 0);
        check("over_held", int'(game_over), 1);
        pulse_start();
        check("restart_score", int'(score), 0);
        check("restart_over", int'(game_over), 0);
        wait_go(200, n);
        check("restart_gap", n, 64);
        check_launch();

        // Timeout; a start pulse mid-flight is ignored.
        for (int i = 0; i < 32; i++) begin
            start = (i == 10);
            tick();
        end
        start = 1'b0;
        check("pre_timeout_fault", int'(fault), 0);
        check("pre_timeout_busy", int'(busy), 1);
        tick();
        check("timeout_fault", int'(fault), 1);
        check("timeout_over", int'(game_over), 1);
        for (int i = 0; i < 5; i++) tick();
        check("fault_sticky", int'(fault), 1);
        pulse_start();
        check("start_clears_fault", int'(fault), 0);
        wait_go(200, n);
        check("post_fault_gap", n, 64);
        check_launch();

        // Reset mid-flight.
        catch_one(n);
        check_launch();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_prev = 3'd0;
        check("rst_busy", int'(busy), 0);
        check("rst_score", int'(score), 0);
        check("rst_addr", int'(drop_if.spawn_addr), 0);
        check("rst_data", int'(drop_if.spawn_data), 0);
        check("rst_go", int'(drop_if.go), 0);

        // Force a repeat column by timing the start against the reference LFSR.
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            p = m_lfsr;
            for (int j = 0; j < 64; j++) p = lfsr_step(p);
            if (p[2:0] == 3'd0) found = 1'b1;
            else tick();
        end
        check("repeat_found", int'(found), 1);
        pulse_start();
        wait_go(200, n);
        check("repeat_gap", n, 64);
        check("repeat_col", int'(drop_if.spawn_addr[5:3]), 1);
        check_launch();

        // Table of single-cycle FLIGHT outcomes, each from a fresh game.
        for (int v = 0; v < 8; v++) begin
            do_reset();
            pulse_start();
            wait_go(200, n);
            check($sformatf("vec%0d_gap", v), n, 64);
            check_launch();
            tick();
            drop_if.obj_done = vecs[v].done;
            drop_if.obj_lose = vecs[v].lose;
            drop_if.obj_addr = vecs[v].addr;
            tick();
            drop_if.obj_done = 1'b0;
            drop_if.obj_lose = 1'b0;
            drop_if.obj_addr = 6'd0;
            check($sformatf("vec%0d_over", v), int'(game_over), int'(vecs[v].exp_over));
            check($sformatf("vec%0d_busy", v), int'(busy), int'(vecs[v].exp_busy));
            check($sformatf("vec%0d_score", v), int'(score), int'(vecs[v].exp_score));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
